picorv_ahb_strobe_bridge: RTL and testbench

- Parametrised PicoRV32 native-memory to FreeAHB master bridge.
- Reads use one full-width transfer. Writes split mem_wstrb into the minimum number of naturally aligned byte, halfword or word AHB transfers; coalescing can be disabled.
- Adds a selectable endian lane map, a bus watchdog with an error return, and a clean abort when mem_valid drops mid-operation.
- Sits between the picorv32 core and the FreeAHB master inside the GRLIB wrapper.

---
 rtl/picorv_ahb_pkg.sv | 33 +++
 rtl/picorv_strobe_splitter.sv | 68 ++++++
 rtl/picorv_ahb_strobe_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_picorv_ahb_strobe_bridge.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/picorv_ahb_pkg.sv
// Shared types and constants for the PicoRV32 to FreeAHB strobe bridge.
package picorv_ahb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE,
    DRAIN
  } state_t;

  // HSIZE encodings
  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HALF  = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] DWORD = 3'b011;

  // HPROT encodings: opcode fetch vs data access
  localparam logic [3:0] PROT_INSTR = 4'b0000;
  localparam logic [3:0] PROT_DATA  = 4'b0001;

  // Ceiling log2, usable in constant expressions
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/picorv_strobe_splitter.sv
// Picks the next naturally aligned AHB write chunk out of a remaining strobe mask.
// The mask is in core strobe-lane order; chunks are chosen in bus byte-offset order.
module picorv_strobe_splitter
  import picorv_ahb_pkg::*;
#(
  parameter int NB         = 4,
  parameter bit COALESCE   = 1'b1,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int OFF_W     = log2(NB)
) (
  input  logic [NB-1:0]    mask,
  output logic [OFF_W-1:0] offset,
  output logic [2:0]       size,
  output logic [NB-1:0]    next_mask,
  output logic             last
);

  // mask re-ordered so that bit o means "byte offset o still to be written"
  logic [NB-1:0] off_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      if (BIG_ENDIAN) begin : g_be
        assign off_mask[gi] = mask[NB-1-gi];
      end else begin : g_le
        assign off_mask[gi] = mask[gi];
      end
    end
  endgenerate

  // Lowest pending offset, then the widest aligned fully-strobed run starting there
  always_comb begin
    int  first;
    int  span;
    int  size_log;
    logic fits;
    first    = 0;
    span     = 1;
    size_log = 0;
    fits     = 1'b0;
    for (int o = NB - 1; o >= 0; o--) begin
      if (off_mask[o]) first = o;
    end
    if (COALESCE) begin
      for (int k = 1; k <= OFF_W; k++) begin
        span = 1 << k;
        fits = ((first % span) == 0) && (first + span <= NB);
        for (int j = 0; j < NB; j++) begin
          if (j >= first && j < first + span && !off_mask[j]) fits = 1'b0;
        end
        // a wider run can only be valid if every narrower one was
        if (fits && size_log == k - 1) size_log = k;
      end
    end
    offset    = OFF_W'(first);
    size      = 3'(size_log);
    next_mask = mask;
    for (int j = 0; j < NB; j++) begin
      if (j >= first && j < first + (1 << size_log)) begin
        if (BIG_ENDIAN) next_mask[NB-1-j] = 1'b0;
        else            next_mask[j]      = 1'b0;
      end
    end
    last = (next_mask == '0);
  end

endmodule

// File: rtl/picorv_ahb_strobe_bridge.sv
// PicoRV32 native memory interface to FreeAHB master request interface.
// Reads are one full-width transfer; writes are split into aligned byte/half/word chunks.
module picorv_ahb_strobe_bridge
  import picorv_ahb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter bit COALESCE   = 1'b1,
  parameter int TIMEOUT    = 1024,
  localparam int NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [NB-1:0]     mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              freeahb_valid,
  output logic [ADDR_W-1:0] freeahb_addr,
  output logic [DATA_W-1:0] freeahb_wdata,
  output logic [2:0]        freeahb_size,
  output logic              freeahb_write,
  output logic              freeahb_read,
  output logic [31:0]       freeahb_min_len,
  output logic              freeahb_cont,
  output logic [3:0]        freeahb_prot,
  output logic              freeahb_lock,
  input  logic              freeahb_next,
  input  logic [DATA_W-1:0] freeahb_rdata,
  input  logic              freeahb_ready
);

  localparam int OFF_W = log2(NB);
  localparam int WD_W  = (TIMEOUT > 2) ? log2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                  state;
  logic [ADDR_W-OFF_W-1:0] base_reg;
  logic [NB-1:0]           mask_reg;     // strobes left after the chunk on the bus
  logic                    last_reg;     // chunk on the bus is the final one
  logic                    drain_rd_reg; // draining a read: wait for its data beat
  logic [WD_W-1:0]         wd_cnt_reg;

  logic [NB-1:0]    split_in;
  logic [OFF_W-1:0] chunk_off;
  logic [2:0]       chunk_size;
  logic [NB-1:0]    chunk_next_mask;
  logic             chunk_last;
  logic             wd_active;
  logic             wd_event;
  logic             wd_fire;
  logic             unused_addr_bits;

  assign freeahb_cont = 1'b0;
  assign freeahb_lock = 1'b0;

  // Write byte position comes from the strobes, never from the low address bits
  assign unused_addr_bits = ^mem_addr[OFF_W-1:0];

  // In IDLE the splitter looks at the incoming strobes so the first chunk is
  // registered on entry to WR_REQ; afterwards it works on the remaining mask.
  assign split_in = (state == IDLE) ? mem_wstrb : mask_reg;

  picorv_strobe_splitter #(
    .NB         (NB),
    .COALESCE   (COALESCE),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_splitter (
    .mask      (split_in),
    .offset    (chunk_off),
    .size      (chunk_size),
    .next_mask (chunk_next_mask),
    .last      (chunk_last)
  );

  // DRAIN is also guarded so a lost data beat cannot wedge the bridge
  assign wd_active = (state == RD_REQ) || (state == RD_WAIT) ||
                     (state == WR_REQ) || (state == DRAIN);
  assign wd_event  = freeahb_next || freeahb_ready;
  assign wd_fire   = (TIMEOUT != 0) && wd_active && !wd_event && (wd_cnt_reg == WD_LAST);

  // Watchdog: cycles since the last bus handshake while a transfer is open
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_reg <= '0;
    end else if (!wd_active || wd_event || wd_fire) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  // Request sequencing with registered bus and core outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      base_reg        <= '0;
      mask_reg        <= '0;
      last_reg        <= 1'b0;
      drain_rd_reg    <= 1'b0;
      mem_ready       <= 1'b0;
      mem_rdata       <= '0;
      mem_err         <= 1'b0;
      freeahb_valid   <= 1'b0;
      freeahb_addr    <= '0;
      freeahb_wdata   <= '0;
      freeahb_size    <= 3'b000;
      freeahb_write   <= 1'b0;
      freeahb_read    <= 1'b0;
      freeahb_min_len <= '0;
      freeahb_prot    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          // while an error pulse is out the core still shows the old request
          if (mem_valid && !mem_ready) begin
            base_reg      <= mem_addr[ADDR_W-1:OFF_W];
            freeahb_prot  <= mem_instr ? PROT_INSTR : PROT_DATA;
            freeahb_valid <= 1'b1;
            if (mem_wstrb == '0) begin
              freeahb_read    <= 1'b1;
              freeahb_write   <= 1'b0;
              freeahb_addr    <= {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              freeahb_size    <= 3'(OFF_W);
              freeahb_min_len <= 32'(DATA_W);
              state           <= RD_REQ;
            end else begin
              freeahb_read    <= 1'b0;
              freeahb_write   <= 1'b1;
              freeahb_wdata   <= mem_wdata;
              freeahb_addr    <= {mem_addr[ADDR_W-1:OFF_W], chunk_off};
              freeahb_size    <= chunk_size;
              freeahb_min_len <= 32'd8 << chunk_size;
              mask_reg        <= chunk_next_mask;
              last_reg        <= chunk_last;
              state           <= WR_REQ;
            end
          end
        end

        RD_REQ: begin
          if (freeahb_next) begin
            freeahb_valid <= 1'b0;
            freeahb_read  <= 1'b0;
            if (!mem_valid) begin
              drain_rd_reg <= 1'b1;
              state        <= freeahb_ready ? IDLE : DRAIN;
            end else if (freeahb_ready) begin
              mem_rdata <= freeahb_rdata;
              mem_ready <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RD_WAIT;
            end
          end else if (!mem_valid) begin
            freeahb_valid <= 1'b0;
            freeahb_read  <= 1'b0;
            state         <= IDLE;
          end else if (wd_fire) begin
            freeahb_valid <= 1'b0;
            freeahb_read  <= 1'b0;
            mem_rdata     <= '1;
            mem_ready     <= 1'b1;
            mem_err       <= 1'b1;
            state         <= IDLE;
          end
        end

        RD_WAIT: begin
          if (freeahb_ready) begin
            if (mem_valid) begin
              mem_rdata <= freeahb_rdata;
              mem_ready <= 1'b1;
              state     <= DONE;
            end else begin
              state <= IDLE;
            end
          end else if (!mem_valid) begin
            drain_rd_reg <= 1'b1;
            state        <= DRAIN;
          end else if (wd_fire) begin
            mem_rdata <= '1;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            state     <= IDLE;
          end
        end

        WR_REQ: begin
          if (freeahb_next) begin
            if (!mem_valid) begin
              freeahb_valid <= 1'b0;
              freeahb_write <= 1'b0;
              drain_rd_reg  <= 1'b0;
              state         <= DRAIN;
            end else if (last_reg) begin
              freeahb_valid <= 1'b0;
              freeahb_write <= 1'b0;
              mem_ready     <= 1'b1;
              state         <= DONE;
            end else begin
              freeahb_addr    <= {base_reg, chunk_off};
              freeahb_size    <= chunk_size;
              freeahb_min_len <= 32'd8 << chunk_size;
              mask_reg        <= chunk_next_mask;
              last_reg        <= chunk_last;
            end
          end else if (!mem_valid) begin
            freeahb_valid <= 1'b0;
            freeahb_write <= 1'b0;
            state         <= IDLE;
          end else if (wd_fire) begin
            freeahb_valid <= 1'b0;
            freeahb_write <= 1'b0;
            mem_rdata     <= '1;
            mem_ready     <= 1'b1;
            mem_err       <= 1'b1;
            state         <= IDLE;
          end
        end

        DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end

        DRAIN: begin
          if (!drain_rd_reg || freeahb_ready || wd_fire) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_ahb_strobe_bridge.sv
// Directed bench: two bridge instances (coalescing on / off), both TIMEOUT=8, big-endian.
module tb_picorv_ahb_strobe_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        sel;        // 0: drive/observe dut_a, 1: dut_b
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        next;
  logic        ready;
  logic [31:0] rdata;

  logic        a_mem_ready, a_mem_err, a_valid, a_write, a_read, a_cont, a_lock;
  logic [31:0] a_mem_rdata, a_addr, a_wdata, a_min_len;
  logic [2:0]  a_size;
  logic [3:0]  a_prot;
  logic        b_mem_ready, b_mem_err, b_valid, b_write, b_read, b_cont, b_lock;
  logic [31:0] b_mem_rdata, b_addr, b_wdata, b_min_len;
  logic [2:0]  b_size;
  logic [3:0]  b_prot;

  picorv_ahb_strobe_bridge #(
    .DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1), .COALESCE(1'b1), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid & ~sel), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(a_mem_ready), .mem_rdata(a_mem_rdata), .mem_err(a_mem_err),
    .freeahb_valid(a_valid), .freeahb_addr(a_addr), .freeahb_wdata(a_wdata),
    .freeahb_size(a_size), .freeahb_write(a_write), .freeahb_read(a_read),
    .freeahb_min_len(a_min_len), .freeahb_cont(a_cont), .freeahb_prot(a_prot),
    .freeahb_lock(a_lock), .freeahb_next(next & ~sel), .freeahb_rdata(rdata),
    .freeahb_ready(ready & ~sel)
  );

  picorv_ahb_strobe_bridge #(
    .DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1), .COALESCE(1'b0), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid & sel), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata), .mem_err(b_mem_err),
    .freeahb_valid(b_valid), .freeahb_addr(b_addr), .freeahb_wdata(b_wdata),
    .freeahb_size(b_size), .freeahb_write(b_write), .freeahb_read(b_read),
    .freeahb_min_len(b_min_len), .freeahb_cont(b_cont), .freeahb_prot(b_prot),
    .freeahb_lock(b_lock), .freeahb_next(next & sel), .freeahb_rdata(rdata),
    .freeahb_ready(ready & sel)
  );

  // observed side of the selected instance
  logic        o_ready, o_err, o_valid, o_write, o_read;
  logic [31:0] o_rdata, o_addr, o_wdata, o_min_len;
  logic [2:0]  o_size;
  logic [3:0]  o_prot;
  assign o_ready   = sel ? b_mem_ready : a_mem_ready;
  assign o_err     = sel ? b_mem_err   : a_mem_err;
  assign o_valid   = sel ? b_valid     : a_valid;
  assign o_write   = sel ? b_write     : a_write;
  assign o_read    = sel ? b_read      : a_read;
  assign o_rdata   = sel ? b_mem_rdata : a_mem_rdata;
  assign o_addr    = sel ? b_addr      : a_addr;
  assign o_wdata   = sel ? b_wdata     : a_wdata;
  assign o_min_len = sel ? b_min_len   : a_min_len;
  assign o_size    = sel ? b_size      : a_size;
  assign o_prot    = sel ? b_prot      : a_prot;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr [3];
  logic [2:0]  exp_size [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bounded wait (at negedges) for freeahb_valid of the selected instance
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (o_valid) break;
      @(negedge clk);
    end
    chk(tag, o_valid, 1'b1);
  endtask

  // Read: accept after the request has been up two cycles, data one cycle later
  task automatic do_read(input logic s, input logic instr, input logic [31:0] addr,
                         input logic [31:0] e_addr, input logic [3:0] e_prot,
                         input logic [31:0] data);
    sel = s; mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wstrb = 4'h0;
    @(negedge clk);
    wait_valid("rd_valid");
    chk("rd_addr", o_addr, e_addr);
    chk("rd_size", o_size, 3'b010);
    chk("rd_read", o_read, 1'b1);
    chk("rd_write", o_write, 1'b0);
    chk("rd_prot", o_prot, e_prot);
    chk("rd_min_len", o_min_len, 32'd32);
    @(negedge clk);
    chk("rd_hold", o_valid, 1'b1);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("rd_valid_drop", o_valid, 1'b0);
    ready = 1'b1; rdata = data;
    @(negedge clk);
    ready = 1'b0;
    chk("rd_ready", o_ready, 1'b1);
    chk("rd_rdata", o_rdata, data);
    chk("rd_err", o_err, 1'b0);
    $display("txn dut=%0d read addr=%h rdata=%h ready=%0b", s, o_addr, o_rdata, o_ready);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rd_ready_pulse", o_ready, 1'b0);
  endtask

  // Write: expect n chunks listed in exp_addr/exp_size, accept each immediately
  task automatic do_write(input logic s, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int n);
    sel = s; mem_valid = 1'b1; mem_instr = 1'b0;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      wait_valid("wr_valid");
      chk("wr_addr", o_addr, exp_addr[c]);
      chk("wr_size", o_size, exp_size[c]);
      chk("wr_min_len", o_min_len, 32'd8 << exp_size[c]);
      chk("wr_write", o_write, 1'b1);
      chk("wr_wdata", o_wdata, wdata);
      chk("wr_early_ready", o_ready, 1'b0);
      $display("txn dut=%0d write chunk=%0d addr=%h size=%0d", s, c, o_addr, o_size);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
    end
    chk("wr_ready", o_ready, 1'b1);
    chk("wr_valid_drop", o_valid, 1'b0);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("wr_ready_pulse", o_ready, 1'b0);
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; sel = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; next = 1'b0; ready = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_ready", a_mem_ready, 1'b0);
    chk("rst_rdata", a_mem_rdata, 32'h0);
    chk("rst_err", a_mem_err, 1'b0);
    chk("rst_prot", a_prot, 4'h0);
    chk("rst_b_valid", b_valid, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    do_read(1'b0, 1'b0, 32'h4000_0004, 32'h4000_0004, 4'b0001, 32'hCAFE_F00D);
    do_read(1'b0, 1'b1, 32'h0000_0102, 32'h0000_0100, 4'b0000, 32'h1234_5678);
    chk("const_cont", a_cont, 1'b0);
    chk("const_lock", a_lock, 1'b0);

    exp_addr[0] = 32'h100; exp_size[0] = 3'b010;
    do_write(1'b0, 32'h100, 32'h1122_3344, 4'b1111, 1);

    exp_addr[0] = 32'h200; exp_size[0] = 3'b000;
    exp_addr[1] = 32'h202; exp_size[1] = 3'b001;
    do_write(1'b0, 32'h200, 32'hAABB_CCDD, 4'b1011, 2);

    exp_addr[0] = 32'h200; exp_size[0] = 3'b000;
    exp_addr[1] = 32'h202; exp_size[1] = 3'b000;
    exp_addr[2] = 32'h203; exp_size[2] = 3'b000;
    do_write(1'b1, 32'h200, 32'hAABB_CCDD, 4'b1011, 3);

    // watchdog: request never accepted
    sel = 1'b0; mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h4000_0010; mem_wstrb = 4'h0;
    @(negedge clk);
    wait_valid("wd_valid");
    cnt = 0;
    while (o_valid && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("wd_valid_cycles", cnt, 8);
    chk("wd_ready", o_ready, 1'b1);
    chk("wd_err", o_err, 1'b1);
    chk("wd_rdata", o_rdata, 32'hFFFF_FFFF);
    $display("txn dut=0 read timeout cycles=%0d err=%0b rdata=%h", cnt, o_err, o_rdata);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("wd_ready_pulse", o_ready, 1'b0);
    chk("wd_err_pulse", o_err, 1'b0);

    // reset while the second chunk of a split write is on the bus
    sel = 1'b0; mem_valid = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h5566_7788; mem_wstrb = 4'b1011;
    @(negedge clk);
    wait_valid("rst_wr_valid");
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("rst_wr_second_addr", o_addr, 32'h202);
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", o_valid, 1'b0);
    chk("rst_mid_addr", o_addr, 32'h0);
    chk("rst_mid_write", o_write, 1'b0);
    chk("rst_mid_size", o_size, 3'b000);
    chk("rst_mid_min_len", o_min_len, 32'h0);
    chk("rst_mid_wdata", o_wdata, 32'h0);
    $display("txn dut=0 reset mid-write valid=%0b addr=%h", o_valid, o_addr);
    mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_addr[0] = 32'h200; exp_size[0] = 3'b000;
    exp_addr[1] = 32'h202; exp_size[1] = 3'b001;
    do_write(1'b0, 32'h200, 32'h5566_7788, 4'b1011, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
